// File: rtl/aud_dsp_player.sv
// Playback DSP: one SRAM fetch per DAC frame, variable rate, hold or linear (AUD_DSP_LINEAR_EN) slow modes.
// Output at tick+3 (hold/fast) or tick+DATA_W+RW+4 (linear); ticks outside WAIT are dropped, no backpressure.
module aud_dsp_player #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 20,
  parameter int MAX_RATE = 8,
  localparam int RW      = $clog2(2*MAX_RATE-1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_rate_up,
  input  logic              i_rate_dn,
  input  logic              i_interp,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic [RW-1:0]     o_rate,
  output logic              o_playing,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_FETCH0 = 3'd2;
  localparam logic [2:0] S_FETCH1 = 3'd3;
  localparam logic [2:0] S_CALC   = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;

  localparam logic [RW-1:0] RATE_MID = RW'(MAX_RATE-1);
  localparam logic [RW-1:0] RATE_MAX = RW'(2*MAX_RATE-2);

  logic [2:0]        state;
  logic              lr_q, tick, playing, done, reuse;
  logic [RW-1:0]     rate, rate_l, p, p_nx;
  logic [ADDR_W-1:0] addr, sram_addr;
  logic [DATA_W-1:0] dac, s0, div_res;
  logic              fast, last, lin_go, div_done, commit, rate_inc, rate_dec;
  logic [RW:0]       d_l, p_inc;
  logic [ADDR_W:0]   k_l, addr_nx;

  assign tick     = lr_q & ~i_daclrck;
  assign playing  = (state == S_WAIT) || (state == S_FETCH0) ||
                    (state == S_FETCH1) || (state == S_CALC);
  assign rate_inc = i_rate_up & ~i_rate_dn & (rate != RATE_MAX);
  assign rate_dec = i_rate_dn & ~i_rate_up & (rate != '0);
  // A pause or stop in the commit cycle discards the result.
  assign commit   = ~i_stop & ~i_pause &
                    (((state == S_FETCH1) & ~lin_go) | div_done);

  // Rate parameters come from the code latched at the tick.
  always_comb begin
    d_l     = (RW+1)'(MAX_RATE) - {1'b0, rate_l};
    k_l     = {{(ADDR_W+1-RW){1'b0}}, rate_l} - (ADDR_W+1)'(MAX_RATE-2);
    p_inc   = {1'b0, p} + (RW+1)'(1);
    fast    = (rate_l >= RATE_MID);
    addr_nx = {1'b0, addr};
    p_nx    = '0;
    if (fast)
      addr_nx = {1'b0, addr} + k_l;
    else if (p_inc == d_l)
      addr_nx = {1'b0, addr} + (ADDR_W+1)'(1);
    else
      p_nx = p_inc[RW-1:0];
    last = addr_nx > {1'b0, i_end_addr};
  end

`ifdef AUD_DSP_LINEAR_EN
  localparam int PW = DATA_W + RW + 1;
  localparam int CW = $clog2(PW);

  logic [CW-1:0]        cnt;
  logic [PW-1:0]        q, q_in, q_nx, mag;
  logic [RW:0]          r, r_in, r_nx;
  logic [RW+1:0]        r_sh;
  logic signed [PW-1:0] num;
  logic [DATA_W-1:0]    s1;
  logic                 neg_q, ge;

  assign lin_go   = i_interp & ~fast;
  assign div_done = (state == S_CALC) && (cnt == CW'(PW-1));
  assign div_res  = neg_q ? -q_nx[DATA_W-1:0] : q_nx[DATA_W-1:0];

  // First CALC cycle forms the numerator and feeds it straight into step 0.
  always_comb begin
    s1   = reuse ? s0 : i_sram_data;
    num  = $signed({{(PW-DATA_W){s0[DATA_W-1]}}, s0}) * $signed(PW'(d_l - {1'b0, p}))
         + $signed({{(PW-DATA_W){s1[DATA_W-1]}}, s1}) * $signed(PW'(p));
    mag  = num[PW-1] ? unsigned'(-num) : unsigned'(num);
    q_in = (cnt == '0) ? mag : q;
    r_in = (cnt == '0) ? '0 : r;
    r_sh = {r_in, q_in[PW-1]};
    ge   = r_sh >= {1'b0, d_l};
    r_nx = ge ? (RW+1)'(r_sh - {1'b0, d_l}) : r_sh[RW:0];
    q_nx = {q_in[PW-2:0], ge};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      neg_q <= 1'b0;
    end else if (state == S_CALC) begin
      cnt <= cnt + CW'(1);
      q   <= q_nx;
      r   <= r_nx;
      if (cnt == '0) neg_q <= num[PW-1];
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_nolin;
  assign lin_go       = 1'b0;
  assign div_done     = 1'b0;
  assign div_res      = '0;
  assign unused_nolin = ^{i_interp, reuse, s0};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      lr_q      <= 1'b0;
      rate      <= RATE_MID;
      rate_l    <= RATE_MID;
      addr      <= '0;
      p         <= '0;
      sram_addr <= '0;
      dac       <= '0;
      s0        <= '0;
      reuse     <= 1'b0;
      done      <= 1'b0;
    end else begin
      lr_q <= i_daclrck;
      done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          state     <= S_WAIT;
          addr      <= '0;
          p         <= '0;
          sram_addr <= '0;
        end
        S_WAIT: if (tick) begin
          state     <= S_FETCH0;
          rate_l    <= rate;
          sram_addr <= addr;
        end
        S_FETCH0: begin
          state <= S_FETCH1;
          reuse <= (addr == i_end_addr);
          if (addr != i_end_addr) sram_addr <= addr + ADDR_W'(1);
        end
        S_FETCH1: begin
          s0 <= i_sram_data;
          if (lin_go) state <= S_CALC;
        end
        S_CALC: ;
        S_PAUSE: if (i_start) state <= S_WAIT;
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        dac <= (state == S_CALC) ? div_res : i_sram_data;
        if (last) begin
          done      <= 1'b1;
          state     <= S_IDLE;
          addr      <= '0;
          p         <= '0;
          sram_addr <= '0;
        end else begin
          state     <= S_WAIT;
          addr      <= addr_nx[ADDR_W-1:0];
          p         <= p_nx;
          sram_addr <= addr_nx[ADDR_W-1:0];
        end
      end

      if (rate_inc) begin
        rate <= rate + RW'(1);
        p    <= '0;
      end else if (rate_dec) begin
        rate <= rate - RW'(1);
        p    <= '0;
      end

      if (i_stop) begin
        state     <= S_IDLE;
        addr      <= '0;
        p         <= '0;
        sram_addr <= '0;
      end else if (i_pause && playing) begin
        state <= S_PAUSE;
      end
    end
  end

  assign o_sram_addr = sram_addr;
  assign o_dac_data  = dac;
  assign o_rate      = rate;
  assign o_playing   = playing;
  assign o_done      = done;

endmodule

// File: tb/tb_aud_dsp_player.sv
// Directed and randomized bench for aud_dsp_player against a frame-level reference model.
module tb_aud_dsp_player;

  localparam int MR = 8;
`ifdef AUD_DSP_LINEAR_EN
  localparam bit LIN_EN = 1'b1;
`else
  localparam bit LIN_EN = 1'b0;
`endif
  localparam int PAUSE_AT = LIN_EN ? 10 : 1;
  localparam int RST_AT   = LIN_EN ? 12 : 2;

  logic        clk = 1'b0;
  logic        rst_n, start, pause, stop, rate_up, rate_dn, interp, daclrck;
  logic [19:0] end_addr;
  logic [15:0] sram_data;
  logic [19:0] sram_addr;
  logic [15:0] dac_data;
  logic [3:0]  rate_o;
  logic        playing, done;

  logic signed [15:0] mem [64];
  int  m_addr, m_p, m_rate, m_end, prev_dac;
  int  passed, total, fails;
  bit  last_ed;
  bit  mon_en = 1'b0;
  bit  bad_read = 1'b0;

  aud_dsp_player dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_rate_up(rate_up), .i_rate_dn(rate_dn), .i_interp(interp), .i_daclrck(daclrck),
    .i_end_addr(end_addr), .i_sram_data(sram_data), .o_sram_addr(sram_addr),
    .o_dac_data(dac_data), .o_rate(rate_o), .o_playing(playing), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_data <= mem[sram_addr[5:0]];

  always @(posedge clk) if (mon_en && sram_addr != '0) bad_read <= 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One DAC frame as the specification describes it, at sample/phase level.
  task automatic model_step(input bit lin, output int ea, output int ev, output bit ed);
    int s0, s1, d, na;
    ea = m_addr;
    s0 = mem[m_addr];
    s1 = (m_addr == m_end) ? s0 : mem[m_addr + 1];
    if (m_rate >= MR - 1) begin
      ev = s0;
      na = m_addr + (m_rate - (MR - 2));
      m_p = 0;
    end else begin
      d  = MR - m_rate;
      ev = lin ? (s0 * (d - m_p) + s1 * m_p) / d : s0;
      if (m_p + 1 == d) begin
        m_p = 0;
        na  = m_addr + 1;
      end else begin
        m_p = m_p + 1;
        na  = m_addr;
      end
    end
    ed = (na > m_end);
    if (ed) begin
      na  = 0;
      m_p = 0;
    end
    m_addr = na;
  endtask

  task automatic frame();
    int ea, ev, lat;
    bit ed, lin;
    lin = interp && LIN_EN && (m_rate < MR - 1);
    lat = lin ? 24 : 3;
    model_step(lin, ea, ev, ed);
    @(negedge clk) daclrck = 1'b1;
    @(negedge clk) daclrck = 1'b0;
    @(negedge clk);
    chk("fetch_addr", {12'b0, sram_addr}, ea);
    repeat (lat - 2) @(negedge clk);
    chk("dac_before_update", $signed(dac_data), prev_dac);
    @(negedge clk);
    chk("dac", $signed(dac_data), ev);
    chk("done", 32'(done), 32'(ed));
    chk("playing", 32'(playing), 32'(!ed));
    if (ed) chk("idle_addr", {12'b0, sram_addr}, 0);
    prev_dac = ev;
    last_ed  = ed;
  endtask

  task automatic rate_pulse(input bit up, input bit dn);
    @(negedge clk);
    rate_up = up;
    rate_dn = dn;
    @(negedge clk);
    rate_up = 1'b0;
    rate_dn = 1'b0;
    if (up && !dn && m_rate < 2*MR - 2) begin m_rate++; m_p = 0; end
    if (dn && !up && m_rate > 0)        begin m_rate--; m_p = 0; end
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic stop_pulse();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    m_addr = 0;
    m_p    = 0;
  endtask

  task automatic set_end(input int e);
    end_addr = 20'(e);
    m_end    = e;
  endtask

  task automatic raw_tick();
    @(negedge clk) daclrck = 1'b1;
    @(negedge clk) daclrck = 1'b0;
  endtask

  initial begin
    int r;
    passed = 0; total = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    rate_up = 1'b0; rate_dn = 1'b0; interp = 1'b0; daclrck = 1'b0;
    m_addr = 0; m_p = 0; m_rate = MR - 1; prev_dac = 0; last_ed = 1'b0;
    set_end(0);
    for (int i = 0; i < 64; i++) mem[i] = 16'(100 * i);

    repeat (3) @(negedge clk);
    chk("rst_dac", $signed(dac_data), 0);
    chk("rst_rate", 32'(rate_o), MR - 1);
    chk("rst_addr", {12'b0, sram_addr}, 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk) rst_n = 1'b1;

    // Normal play 0..5
    set_end(5);
    start_pulse();
    for (int i = 0; i < 6; i++) frame();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);

    // Fast playback and rate saturation
    rate_pulse(1, 0);
    rate_pulse(1, 0);
    chk("rate_fast", 32'(rate_o), m_rate);
    set_end(20);
    start_pulse();
    for (int i = 0; i < 3; i++) frame();
    stop_pulse();
    chk("stop_playing", 32'(playing), 0);
    chk("stop_addr", {12'b0, sram_addr}, 0);
    for (int i = 0; i < 10; i++) rate_pulse(1, 0);
    chk("rate_sat_hi", 32'(rate_o), 14);
    rate_pulse(1, 1);
    chk("rate_up_dn", 32'(rate_o), 14);

    // Slow hold, d = 4
    for (int i = 0; i < 10; i++) rate_pulse(0, 1);
    chk("rate_slow", 32'(rate_o), 4);
    interp = 1'b0;
    start_pulse();
    for (int i = 0; i < 9; i++) frame();
    stop_pulse();

    // Slow linear, d = 4
    interp = 1'b1;
    mem[0] = 16'sd0;
    mem[1] = 16'sd400;
    start_pulse();
    for (int i = 0; i < 5; i++) frame();
    stop_pulse();
    mem[0] = -16'sd400;
    mem[1] = 16'sd0;
    start_pulse();
    for (int i = 0; i < 4; i++) frame();
    stop_pulse();

    // Pause in the middle of a frame, then resume and recompute
    start_pulse();
    raw_tick();
    repeat (PAUSE_AT) @(negedge clk);
    pause = 1'b1;
    @(negedge clk) pause = 1'b0;
    chk("pause_playing", 32'(playing), 0);
    repeat (30) @(negedge clk);
    chk("pause_dac_held", $signed(dac_data), prev_dac);
    start_pulse();
    frame();

    // Stop and pause together
    raw_tick();
    repeat (2) @(negedge clk);
    stop = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    pause = 1'b0;
    m_addr = 0;
    m_p = 0;
    chk("stop_pause_playing", 32'(playing), 0);
    chk("stop_pause_addr", {12'b0, sram_addr}, 0);

    // Asynchronous reset in the middle of a frame
    start_pulse();
    raw_tick();
    repeat (RST_AT) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_dac", $signed(dac_data), 0);
    chk("arst_rate", 32'(rate_o), MR - 1);
    chk("arst_addr", {12'b0, sram_addr}, 0);
    chk("arst_playing", 32'(playing), 0);
    @(negedge clk) rst_n = 1'b1;
    m_rate = MR - 1; m_addr = 0; m_p = 0; prev_dac = 0;

    // End boundary: end = 0, d = 2, second sample reuses the first
    rate_pulse(0, 1);
    set_end(0);
    mem[0] = 16'sd50;
    interp = 1'b1;
    mon_en = 1'b1;
    start_pulse();
    frame();
    frame();
    mon_en = 1'b0;
    chk("no_read_past_end", 32'(bad_read), 0);

    // Randomized playback
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    set_end($urandom_range(8, 30));
    start_pulse();
    for (int n = 0; n < 16; n++) begin
      r = $urandom_range(0, 3);
      if (r == 1) rate_pulse(1, 0);
      else if (r == 2) rate_pulse(0, 1);
      else if (r == 3) rate_pulse(1, 1);
      chk("rand_rate", 32'(rate_o), m_rate);
      interp = 1'($urandom_range(0, 1));
      frame();
      if (last_ed) start_pulse();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
